miriscv_mem_arbiter: RTL and testbench
======================================

// Module: miriscv_mem_arbiter
// PURPOSE
//  Shares one single-port memory between the miriscv instruction-fetch and data ports.
//  Arbitrates requests and allows one outstanding transaction at a time.
//  Routes the memory response back to the owning port and flags a sticky error when memory hangs.
//  Sits between the core and the memory model used by the hammer co-simulation bench.
// PARAMETERS
//  ADDR_W     32   address width, both requester ports and memory port
//  DATA_W     32   data width; byte-enable width is DATA_W/8
//  DATA_PRIO  1    1: data port always wins a conflict; 0: round-robin on conflict
//  TIMEOUT    255  max cycles in RESP waiting for mem_rvalid_i; 0 disables timeout
// PORTS
//  clk_i          in   1         clock, all logic on rising edge
//  rst_i          in   1         synchronous, active-high reset
//  instr_req_i    in   1         fetch request; held with addr stable until instr_gnt_o
//  instr_addr_i   in   ADDR_W    fetch address
//  instr_gnt_o    out  1         fetch request captured this cycle
//  instr_rvalid_o out  1         fetch response valid (1-cycle pulse)
//  instr_rdata_o  out  DATA_W    fetch response data
//  data_req_i     in   1         load/store request; held with fields stable until data_gnt_o
//  data_we_i      in   1         1 = store
//  data_be_i      in   DATA_W/8  byte enables
//  data_addr_i    in   ADDR_W    data address
//  data_wdata_i   in   DATA_W    store data
//  data_gnt_o     out  1         data request captured this cycle
//  data_rvalid_o  out  1         data response valid (1-cycle pulse; also returned for stores)
//  data_rdata_o   out  DATA_W    load data
//  mem_req_o      out  1         memory request; held with fields stable until mem_gnt_i
//  mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o  out  1/DATA_W/8/ADDR_W/DATA_W  latched request fields
//  mem_gnt_i      in   1         memory accepted request
//  mem_rvalid_i   in   1         memory response valid
//  mem_rdata_i    in   DATA_W    memory response data
//  busy_o         out  1         state != IDLE
//  timeout_o      out  1         sticky: memory response timed out
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs are 0. owner=INSTR. last_owner=DATA. Timeout counter=0.
//  - FSM IDLE -> REQ -> RESP -> IDLE. ERR is absorbing and is left only by rst_i.
//  - IDLE: if any req_i is high, pick the winner and assert its gnt_o combinationally.
//    On that edge, latch owner and request fields (instr fetch: we=0, be=all ones, wdata=0). Go to REQ.
//    - Only one request: that port wins.
//    - Conflict: the data port wins if DATA_PRIO=1; otherwise the port != last_owner wins.
//    - last_owner updates on every grant.
//  - REQ: mem_req_o=1 with latched fields. Go to RESP on the edge where mem_gnt_i=1.
//  - RESP: counter increments each cycle. On mem_rvalid_i: register rdata into the owner's rdata_o.
//    Pulse the owner's rvalid_o the next cycle, clear the counter, go to IDLE.
//    - The other port's rvalid_o stays 0.
//    - rdata_o holds its last value between responses.
//  - Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT with no rvalid, go to ERR and set timeout_o=1.
//    - ERR: no grants, mem_req_o=0, rvalid_o=0, busy_o=1.
//  - mem_rvalid_i outside RESP is ignored (no rvalid_o, no state change).
//  - Min latency: req@c0 -> gnt_o@c0 -> mem_req_o@c1 (gnt@c1) -> mem_rvalid_i@c2 -> rvalid_o@c3.
//    The next grant is possible at c3 (back-to-back throughput: 1 access per 3 cycles).
//  - Reset mid-transaction: next edge gives IDLE with all outputs 0. A late mem_rvalid_i is ignored.
//  - Counter width is $clog2(TIMEOUT+1) and saturates; it never wraps.
// TESTING
//  T1 single fetch: instr_req_i=1 addr=0x80 @c0; mem_gnt_i=1 @c1; mem_rvalid_i=1 rdata=0x00000013 @c2
//     -> instr_gnt_o@c0, mem_addr_o=0x80 @c1, instr_rvalid_o=1 rdata=0x13 @c3, data_rvalid_o=0 throughout
//  T2 conflict, DATA_PRIO=1: both req same cycle, data store addr=0x100 be=0xF wdata=0xDEADBEEF
//     -> data_gnt_o first, mem_we_o=1 mem_wdata_o=0xDEADBEEF; instr granted only after data_rvalid_o
//  T3 conflict, DATA_PRIO=0: 4 back-to-back conflicts -> grant order INSTR, DATA, INSTR, DATA
//  T4 gnt stall: mem_gnt_i=0 for 5 cycles -> mem_req_o and fields stay stable 5 cycles; no new gnt_o
//  T5 timeout, TIMEOUT=4: no mem_rvalid_i after gnt -> timeout_o=1 after 4 cycles in RESP
//     -> later requests get no gnt_o; rst_i=1 clears timeout_o and returns to IDLE
//  T6 reset in RESP, then mem_rvalid_i=1 the next cycle -> no rvalid_o pulse, busy_o=0

Source files
------------

// File: rtl/miriscv_mem_arbiter.sv
// Shares one single-port memory between the miriscv fetch and data ports,
// one outstanding transaction at a time, with a sticky response-timeout flag.
module miriscv_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DATA_PRIO = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,

  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,

  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_e;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;

  state_e           state;
  owner_e           owner;
  owner_e           last_owner;
  logic [CNT_W-1:0] cnt;
  logic             grant_instr;
  logic             grant_data;
  logic             cnt_hit;

  // Grants are combinational so the requester sees gnt in the same cycle it asks.
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (state == S_IDLE && !rst_i) begin
      if (instr_req_i && data_req_i) begin
        if (DATA_PRIO != 0 || last_owner == OWN_INSTR) grant_data  = 1'b1;
        else                                           grant_instr = 1'b1;
      end else begin
        grant_instr = instr_req_i;
        grant_data  = data_req_i;
      end
    end
  end

  assign instr_gnt_o = grant_instr;
  assign data_gnt_o  = grant_data;
  assign busy_o      = (state != S_IDLE);
  assign cnt_hit     = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) >= TIMEOUT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      owner          <= OWN_INSTR;
      last_owner     <= OWN_DATA;
      cnt            <= '0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_be_o       <= '0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      instr_rvalid_o <= 1'b0;
      instr_rdata_o  <= '0;
      data_rvalid_o  <= 1'b0;
      data_rdata_o   <= '0;
      timeout_o      <= 1'b0;
    end else begin
      instr_rvalid_o <= 1'b0;
      data_rvalid_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_data) begin
            state       <= S_REQ;
            mem_req_o   <= 1'b1;
            owner       <= OWN_DATA;
            last_owner  <= OWN_DATA;
            mem_we_o    <= data_we_i;
            mem_be_o    <= data_be_i;
            mem_addr_o  <= data_addr_i;
            mem_wdata_o <= data_wdata_i;
          end else if (grant_instr) begin
            state       <= S_REQ;
            mem_req_o   <= 1'b1;
            owner       <= OWN_INSTR;
            last_owner  <= OWN_INSTR;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '1;
            mem_addr_o  <= instr_addr_i;
            mem_wdata_o <= '0;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            state     <= S_RESP;
            mem_req_o <= 1'b0;
            cnt       <= '0;
          end
        end
        S_RESP: begin
          if (mem_rvalid_i) begin
            state <= S_IDLE;
            cnt   <= '0;
            if (owner == OWN_DATA) begin
              data_rdata_o  <= mem_rdata_i;
              data_rvalid_o <= 1'b1;
            end else begin
              instr_rdata_o  <= mem_rdata_i;
              instr_rvalid_o <= 1'b1;
            end
          end else begin
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
            if (cnt_hit) begin
              state     <= S_ERR;
              timeout_o <= 1'b1;
            end
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Randomized scoreboard bench for miriscv_mem_arbiter: two instances
// (data-priority/long timeout and round-robin/short timeout) each with its own model.
`timescale 1ns/1ps
module tb_miriscv_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    bit            is_data;
    bit            we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;

  typedef struct {
    bit            is_data;
    logic [DW-1:0] rdata;
  } resp_t;

  function automatic void check(string name, int unsigned inst, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=0x%0h required=0x%0h", name, inst, $time, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned PRIO   = (g == 0) ? 1 : 0;
    localparam int unsigned TO     = (g == 0) ? 255 : 4;
    localparam int unsigned MAXLAT = (g == 0) ? 6 : 2;

    logic          rst_i = 1'b1;
    logic          instr_req_i = 1'b0;
    logic [AW-1:0] instr_addr_i = '0;
    logic          instr_gnt_o, instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i = 1'b0;
    logic          data_we_i = 1'b0;
    logic [BW-1:0] data_be_i = '0;
    logic [AW-1:0] data_addr_i = '0;
    logic [DW-1:0] data_wdata_i = '0;
    logic          data_gnt_o, data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          busy_o, timeout_o;

    miriscv_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .DATA_PRIO(PRIO), .TIMEOUT(TO)
    ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .timeout_o(timeout_o)
    );

    // Reference model: transaction-level view of the one-outstanding protocol.
    bit            in_flight, req_pending, in_mem, resp_due, err, last_data, just_reset;
    bit            pend_data;
    int unsigned   wait_cyc;
    logic [DW-1:0] last_i, last_d;
    mreq_t         exp_mem[$];
    resp_t         exp_resp[$];
    mreq_t         e;
    resp_t         r;
    bit            cur_i, cur_d, win_i, win_d;

    always @(negedge clk) begin
      if (rst_i) begin
        in_flight = 0; req_pending = 0; in_mem = 0; resp_due = 0; err = 0;
        last_data = 1; just_reset = 1; wait_cyc = 0;
        last_i = '0; last_d = '0;
        exp_mem.delete(); exp_resp.delete();
      end else begin
        cur_i = 0; cur_d = 0;
        if (resp_due) begin
          r = exp_resp.pop_front();
          cur_d = r.is_data;
          cur_i = !r.is_data;
        end
        check("instr_rvalid", g, instr_rvalid_o, cur_i);
        check("data_rvalid", g, data_rvalid_o, cur_d);
        if (resp_due) begin
          if (r.is_data) last_d = r.rdata;
          else           last_i = r.rdata;
          in_flight = 0;
          resp_due  = 0;
        end
        check("instr_rdata", g, instr_rdata_o, last_i);
        check("data_rdata", g, data_rdata_o, last_d);
        check("busy", g, busy_o, in_flight || err);
        check("timeout", g, timeout_o, err);
        check("mem_req", g, mem_req_o, req_pending);
        if (req_pending) begin
          e = exp_mem[0];
          check("mem_we", g, mem_we_o, e.we);
          check("mem_be", g, mem_be_o, e.be);
          check("mem_addr", g, mem_addr_o, e.addr);
          check("mem_wdata", g, mem_wdata_o, e.wdata);
        end
        if (just_reset) begin
          check("rst_mem_fields", g, {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 64'd0);
          just_reset = 0;
        end
        win_i = 0; win_d = 0;
        if (!in_flight && !err) begin
          if (instr_req_i && data_req_i) begin
            if (PRIO != 0 || !last_data) win_d = 1;
            else                         win_i = 1;
          end else begin
            win_i = instr_req_i;
            win_d = data_req_i;
          end
        end
        check("instr_gnt", g, instr_gnt_o, win_i);
        check("data_gnt", g, data_gnt_o, win_d);
        if (in_mem) begin
          if (mem_rvalid_i) begin
            r.is_data = pend_data;
            r.rdata   = mem_rdata_i;
            exp_resp.push_back(r);
            in_mem   = 0;
            resp_due = 1;
          end else begin
            wait_cyc++;
            if (TO != 0 && wait_cyc >= TO) begin
              in_mem = 0;
              err    = 1;
            end
          end
        end
        if (req_pending && mem_gnt_i) begin
          e = exp_mem.pop_front();
          pend_data   = e.is_data;
          req_pending = 0;
          in_mem      = 1;
          wait_cyc    = 0;
        end
        if (win_i || win_d) begin
          e.is_data = win_d;
          e.we      = win_d ? data_we_i : 1'b0;
          e.be      = win_d ? data_be_i : {BW{1'b1}};
          e.addr    = win_d ? data_addr_i : instr_addr_i;
          e.wdata   = win_d ? data_wdata_i : '0;
          exp_mem.push_back(e);
          in_flight   = 1;
          req_pending = 1;
          last_data   = win_d;
        end
      end
    end

    // Stimulus: two requesters and a memory with random latency and stalls.
    int unsigned   ireq_rate, dreq_rate, rv_spur, stall, lat;
    bit            mem_acc, mem_hold;
    logic [DW-1:0] mem_arr [16];
    logic [DW-1:0] resp_data;

    task automatic step();
      bit ig, dg, acc;
      logic [3:0] idx;
      @(negedge clk);
      ig  = instr_gnt_o;
      dg  = data_gnt_o;
      acc = mem_req_o && mem_gnt_i;
      @(posedge clk);
      #1;
      if (instr_req_i && ig) instr_req_i = 1'b0;
      if (!instr_req_i && $urandom_range(0, 99) < ireq_rate) begin
        instr_req_i  = 1'b1;
        instr_addr_i = {26'h0, 4'($urandom), 2'b00} + 32'h80;
      end
      if (data_req_i && dg) data_req_i = 1'b0;
      if (!data_req_i && $urandom_range(0, 99) < dreq_rate) begin
        data_req_i   = 1'b1;
        data_we_i    = 1'($urandom);
        data_be_i    = 4'($urandom);
        data_addr_i  = {26'h0, 4'($urandom), 2'b00};
        data_wdata_i = $urandom;
      end
      if (acc) begin
        idx = mem_addr_o[5:2];
        if (mem_we_o) begin
          for (int b = 0; b < BW; b++)
            if (mem_be_o[b]) mem_arr[idx][8*b +: 8] = mem_wdata_o[8*b +: 8];
          resp_data = $urandom;
        end else begin
          resp_data = mem_arr[idx];
        end
        mem_acc = 1;
        lat     = $urandom_range(0, MAXLAT);
      end
      if (stall > 0) begin
        stall--;
        mem_gnt_i = 1'b0;
      end else if ($urandom_range(0, 99) < 5) begin
        stall     = 5;
        mem_gnt_i = 1'b0;
      end else begin
        mem_gnt_i = ($urandom_range(0, 99) < 60);
      end
      mem_rdata_i  = $urandom;
      mem_rvalid_i = 1'b0;
      if (mem_acc) begin
        if (!mem_hold) begin
          if (lat == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = resp_data;
            mem_acc      = 0;
          end else begin
            lat--;
          end
        end
      end else if ($urandom_range(0, 99) < rv_spur) begin
        mem_rvalid_i = 1'b1;
      end
    endtask

    task automatic drain();
      int unsigned n = 0;
      ireq_rate = 0;
      dreq_rate = 0;
      while ((instr_req_i || data_req_i || in_flight) && n < 400) begin
        step();
        n++;
      end
      if (n >= 400) begin
        checks++;
        failures++;
        $display("FAIL drain_bound dut%0d t=%0t actual=busy required=idle", g, $time);
      end
    endtask

    task automatic wait_accept();
      int unsigned n = 0;
      while (!mem_acc && n < 200) begin
        step();
        n++;
      end
      if (!mem_acc) begin
        checks++;
        failures++;
        $display("FAIL accept_bound dut%0d t=%0t actual=no_mem_gnt required=accepted", g, $time);
      end
    endtask

    initial begin
      for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
      ireq_rate = 0; dreq_rate = 0; rv_spur = 10; stall = 0;
      mem_acc = 0; mem_hold = 0; lat = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;

      for (int n = 0; n < 1500; n++) begin
        if (n % 250 == 0) begin
          ireq_rate = $urandom_range(10, 100);
          dreq_rate = $urandom_range(10, 100);
        end
        step();
      end
      drain();

      // Reset while waiting in RESP, then a late memory response.
      rv_spur  = 0;
      mem_hold = 1;
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = '1;
      data_addr_i = 32'h10; data_wdata_i = '0;
      wait_accept();
      rst_i = 1'b1;
      mem_acc = 0;
      @(posedge clk);
      #1;
      rst_i        = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hA5A5A5A5;
      mem_gnt_i    = 1'b0;
      @(posedge clk);
      #1;
      mem_rvalid_i = 1'b0;
      #1;
      check("late_rvalid_data", g, data_rvalid_o, 0);
      check("late_rvalid_instr", g, instr_rvalid_o, 0);
      check("late_rvalid_busy", g, busy_o, 0);
      check("late_rvalid_rdata", g, data_rdata_o, 0);

      // Memory never answers: sticky timeout, no further grants until reset.
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h80;
      wait_accept();
      repeat (TO + 2) step();
      ireq_rate = 100;
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
      data_addr_i = 32'h100; data_wdata_i = 32'hDEADBEEF;
      repeat (5) step();
      #1;
      check("timeout_sticky", g, timeout_o, 1);
      check("timeout_busy", g, busy_o, 1);
      check("timeout_no_mem_req", g, mem_req_o, 0);
      rst_i   = 1'b1;
      mem_acc = 0;
      @(posedge clk);
      #1;
      rst_i    = 1'b0;
      mem_hold = 0;
      #1;
      check("timeout_cleared", g, timeout_o, 0);
      check("reset_idle", g, busy_o, 0);
      rv_spur = 10;
      drain();
      done_cnt++;
    end
  end

  initial begin
    wait (done_cnt == 2);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500us;
    checks++;
    failures++;
    $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
